swervolf_wb_initiator: RTL and testbench

Single-outstanding Wishbone classic initiator that issues read/write cycles to the SoC-level peripheral register slaves, such as the system controller and the seven-segment display registers. It sits between a simple valid/ready command port, driven by a debug/test sequencer or a display-update engine, and the peripheral Wishbone bus. It returns the read data, or an error flag on bus timeout, through a valid/ready response port.

---
 rtl/swervolf_wb_initiator.sv | 138 +++++++++++++
 tb/tb_swervolf_wb_initiator.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swervolf_wb_initiator.sv
// Single-outstanding Wishbone classic initiator: a valid/ready command port in,
// a valid/ready response port out (read data, or an error flag on ack timeout).
module swervolf_wb_initiator #(
    parameter int ADR_WIDTH = 6,
    parameter int TIMEOUT   = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_we,
    input  logic [ADR_WIDTH-1:0] i_cmd_adr,
    input  logic [31:0]          i_cmd_dat,
    input  logic [3:0]           i_cmd_sel,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [31:0]          o_rsp_dat,
    output logic                 o_rsp_err,
    output logic [ADR_WIDTH-1:0] o_wb_adr,
    output logic [31:0]          o_wb_dat,
    output logic [3:0]           o_wb_sel,
    output logic                 o_wb_we,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    input  logic [31:0]          i_wb_rdt,
    input  logic                 i_wb_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t                 state_r;
    logic [15:0]            cnt_r;
    logic [ADR_WIDTH-1:0]   wb_adr_r;
    logic [31:0]            wb_dat_r;
    logic [3:0]             wb_sel_r;
    logic                   wb_we_r;
    logic                   wb_cyc_r;
    logic                   rsp_valid_r;
    logic [31:0]            rsp_dat_r;
    logic                   rsp_err_r;
    logic                   cmd_fire_s;
    logic                   expire_s;

    // Ready depends only on state so a command never waits on its own valid.
    assign o_cmd_ready = (state_r == IDLE) & ~i_rst;

    // Handshake and timeout-expiry decode.
    always_comb begin
        cmd_fire_s = 1'b0;
        expire_s   = 1'b0;
        if (i_cmd_valid && o_cmd_ready) begin
            cmd_fire_s = 1'b1;
        end else begin
            cmd_fire_s = 1'b0;
        end
        if ((TIMEOUT_C != 16'd0) && (cnt_r == 16'd1)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    // Transaction FSM; every bus and response output is a register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= IDLE;
            cnt_r       <= 16'd0;
            wb_adr_r    <= '0;
            wb_dat_r    <= 32'd0;
            wb_sel_r    <= 4'd0;
            wb_we_r     <= 1'b0;
            wb_cyc_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_dat_r   <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_fire_s) begin
                        wb_adr_r <= i_cmd_adr;
                        wb_dat_r <= i_cmd_dat;
                        wb_sel_r <= i_cmd_sel;
                        wb_we_r  <= i_cmd_we;
                        wb_cyc_r <= 1'b1;
                        cnt_r    <= TIMEOUT_C;
                        state_r  <= BUS;
                    end
                end
                BUS: begin
                    // Ack takes priority over a simultaneous timeout expiry.
                    if (i_wb_ack) begin
                        rsp_dat_r   <= wb_we_r ? 32'd0 : i_wb_rdt;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        wb_cyc_r    <= 1'b0;
                        state_r     <= RESP;
                    end else if (expire_s) begin
                        rsp_dat_r   <= 32'd0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        wb_cyc_r    <= 1'b0;
                        state_r     <= RESP;
                    end else if (TIMEOUT_C != 16'd0) begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    wb_cyc_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign o_wb_adr    = wb_adr_r;
    assign o_wb_dat    = wb_dat_r;
    assign o_wb_sel    = wb_sel_r;
    assign o_wb_we     = wb_we_r;
    assign o_wb_cyc    = wb_cyc_r;
    assign o_wb_stb    = wb_cyc_r;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_dat   = rsp_dat_r;
    assign o_rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_swervolf_wb_initiator.sv
// Directed bench: instance A talks to a syscon-like register model, B (TIMEOUT=4)
// sees a silent bus, C (TIMEOUT=3) gets a hand-placed ack.
module tb_swervolf_wb_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rsp_ready = 1'b0;
    logic        cmd_we = 1'b0;
    logic [5:0]  cmd_adr = 6'd0;
    logic [31:0] cmd_dat = 32'd0;
    logic [3:0]  cmd_sel = 4'd0;
    logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
    logic        stray = 1'b0;
    logic        ack_c = 1'b0;
    logic [31:0] rdt_c = 32'd0;
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'd0;

    logic        cmd_ready_a, rsp_valid_a, rsp_err_a, wb_we_a, wb_cyc_a, wb_stb_a;
    logic [31:0] rsp_dat_a, wb_dat_a;
    logic [5:0]  wb_adr_a;
    logic [3:0]  wb_sel_a;
    logic        cmd_ready_b, rsp_valid_b, rsp_err_b, wb_we_b, wb_cyc_b, wb_stb_b;
    logic [31:0] rsp_dat_b, wb_dat_b;
    logic [5:0]  wb_adr_b;
    logic [3:0]  wb_sel_b;
    logic        cmd_ready_c, rsp_valid_c, rsp_err_c, wb_we_c, wb_cyc_c, wb_stb_c;
    logic [31:0] rsp_dat_c, wb_dat_c;
    logic [5:0]  wb_adr_c;
    logic [3:0]  wb_sel_c;

    logic [31:0] mem [16];
    logic        ack_m = 1'b0;
    logic [31:0] rdt_m = 32'd0;
    logic        ack_a;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ack_a = ack_m | stray;

    // Register-slave model: ack <= cyc & !ack, read data registered with ack.
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        if (rst) begin
            ack_m <= 1'b0;
        end else begin
            ack_m <= wb_cyc_a & wb_stb_a & ~ack_m;
            if (wb_cyc_a && wb_stb_a && !ack_m) begin
                rdt_m <= mem[wb_adr_a[5:2]];
                if (wb_we_a) begin
                    for (int b = 0; b < 4; b++)
                        if (wb_sel_a[b]) mem[wb_adr_a[5:2]][8*b +: 8] <= wb_dat_a[8*b +: 8];
                end
            end
        end
    end

    swervolf_wb_initiator #(.ADR_WIDTH(6), .TIMEOUT(255)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid_a), .o_cmd_ready(cmd_ready_a),
        .i_cmd_we(cmd_we), .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat), .i_cmd_sel(cmd_sel),
        .o_rsp_valid(rsp_valid_a), .i_rsp_ready(rsp_ready), .o_rsp_dat(rsp_dat_a),
        .o_rsp_err(rsp_err_a), .o_wb_adr(wb_adr_a), .o_wb_dat(wb_dat_a), .o_wb_sel(wb_sel_a),
        .o_wb_we(wb_we_a), .o_wb_cyc(wb_cyc_a), .o_wb_stb(wb_stb_a),
        .i_wb_rdt(rdt_m), .i_wb_ack(ack_a));

    swervolf_wb_initiator #(.ADR_WIDTH(6), .TIMEOUT(4)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid_b), .o_cmd_ready(cmd_ready_b),
        .i_cmd_we(cmd_we), .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat), .i_cmd_sel(cmd_sel),
        .o_rsp_valid(rsp_valid_b), .i_rsp_ready(rsp_ready), .o_rsp_dat(rsp_dat_b),
        .o_rsp_err(rsp_err_b), .o_wb_adr(wb_adr_b), .o_wb_dat(wb_dat_b), .o_wb_sel(wb_sel_b),
        .o_wb_we(wb_we_b), .o_wb_cyc(wb_cyc_b), .o_wb_stb(wb_stb_b),
        .i_wb_rdt(32'd0), .i_wb_ack(1'b0));

    swervolf_wb_initiator #(.ADR_WIDTH(6), .TIMEOUT(3)) u_dut_c (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid_c), .o_cmd_ready(cmd_ready_c),
        .i_cmd_we(cmd_we), .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat), .i_cmd_sel(cmd_sel),
        .o_rsp_valid(rsp_valid_c), .i_rsp_ready(rsp_ready), .o_rsp_dat(rsp_dat_c),
        .o_rsp_err(rsp_err_c), .o_wb_adr(wb_adr_c), .o_wb_dat(wb_dat_c), .o_wb_sel(wb_sel_c),
        .o_wb_we(wb_we_c), .o_wb_cyc(wb_cyc_c), .o_wb_stb(wb_stb_c),
        .i_wb_rdt(rdt_c), .i_wb_ack(ack_c));

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Issue one command on A; lat is the cycle index (acceptance cycle = 0) where
    // rsp_valid is first seen, 0 if never within the budget.
    task automatic run_cmd_a(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output int lat, output int cyc_cnt,
                             output logic acc, output logic [5:0] b_adr, output logic [31:0] b_dat,
                             output logic [3:0] b_sel, output logic b_we);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; valid_a = 1'b1;
        acc = cmd_ready_a;
        @(posedge clk); #1;
        valid_a = 1'b0;
        lat = 0; cyc_cnt = 0;
        b_adr = wb_adr_a; b_dat = wb_dat_a; b_sel = wb_sel_a; b_we = wb_we_a;
        for (int k = 1; k <= 50; k++) begin
            if (rsp_valid_a) begin
                lat = k;
                break;
            end
            if (wb_cyc_a) cyc_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (cmd_ready_a !== 1'b0 || wb_cyc_a !== 1'b0 || wb_stb_a !== 1'b0 || rsp_valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: ready=%b cyc=%b stb=%b rsp_valid=%b, required 0 0 0 0",
                     cmd_ready_a, wb_cyc_a, wb_stb_a, rsp_valid_a);
        end
        n_cmp++;
        if (rsp_err_a !== 1'b0 || rsp_dat_a !== 32'd0 || wb_adr_a !== 6'd0 || wb_dat_a !== 32'd0 ||
            wb_sel_a !== 4'd0 || wb_we_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_data: err=%b dat=%h adr=%h wdat=%h sel=%h we=%b, required all zero",
                     rsp_err_a, rsp_dat_a, wb_adr_a, wb_dat_a, wb_sel_a, wb_we_a);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready_a !== 1'b1 || cmd_ready_b !== 1'b1 || cmd_ready_c !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: a=%b b=%b c=%b, required 1 1 1",
                     cmd_ready_a, cmd_ready_b, cmd_ready_c);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        int lat, cc; logic acc, bwe; logic [5:0] badr; logic [31:0] bdat; logic [3:0] bsel;
        preload(4'd4, 32'd0);
        preload(4'd12, 32'hCAFEF00D);
        run_cmd_a(1'b1, 6'h3C, 32'h12345678, 4'hF, lat, cc, acc, badr, bdat, bsel, bwe);
        n_cmp++;
        if (acc !== 1'b1 || lat != 3 || cc != 2) begin
            n_err++;
            $display("FAIL write_timing: acc=%b lat=%0d cyc=%0d, required 1 3 2", acc, lat, cc);
        end
        n_cmp++;
        if (badr !== 6'h3C || bdat !== 32'h12345678 || bsel !== 4'hF || bwe !== 1'b1) begin
            n_err++;
            $display("FAIL write_bus: adr=%h dat=%h sel=%h we=%b, required 3c 12345678 f 1",
                     badr, bdat, bsel, bwe);
        end
        n_cmp++;
        if (rsp_err_a !== 1'b0 || rsp_dat_a !== 32'd0 || wb_cyc_a !== 1'b0 || mem[15] !== 32'h12345678) begin
            n_err++;
            $display("FAIL write_rsp: err=%b dat=%h cyc=%b digits=%h, required 0 0 0 12345678",
                     rsp_err_a, rsp_dat_a, wb_cyc_a, mem[15]);
        end
        consume();
        n_cmp++;
        if (rsp_valid_a !== 1'b0 || cmd_ready_a !== 1'b1) begin
            n_err++;
            $display("FAIL write_handshake: valid=%b ready=%b, required 0 1", rsp_valid_a, cmd_ready_a);
        end
    endtask

    task automatic test_read();
        int lat, cc; logic acc, bwe; logic [5:0] badr; logic [31:0] bdat; logic [3:0] bsel;
        run_cmd_a(1'b0, 6'h30, 32'd0, 4'hF, lat, cc, acc, badr, bdat, bsel, bwe);
        n_cmp++;
        if (lat != 3 || cc != 2 || badr !== 6'h30 || bwe !== 1'b0) begin
            n_err++;
            $display("FAIL read_timing: lat=%0d cyc=%0d adr=%h we=%b, required 3 2 30 0", lat, cc, badr, bwe);
        end
        n_cmp++;
        if (rsp_dat_a !== 32'hCAFEF00D || rsp_err_a !== 1'b0) begin
            n_err++;
            $display("FAIL read_data: dat=%h err=%b, required cafef00d 0", rsp_dat_a, rsp_err_a);
        end
        consume();
    endtask

    task automatic test_timeout();
        int lat = 0, cc = 0, bad_ready = 0, bad_bus = 0;
        cmd_we = 1'b0; cmd_adr = 6'h20; cmd_dat = 32'd0; cmd_sel = 4'hF; valid_b = 1'b1;
        @(posedge clk); #1;
        valid_b = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            if (cmd_ready_b !== 1'b0) bad_ready++;
            if (rsp_valid_b) begin
                lat = k;
                break;
            end
            if (wb_stb_b !== wb_cyc_b) bad_bus++;
            if (wb_cyc_b) begin
                cc++;
                if (wb_adr_b !== 6'h20 || wb_we_b !== 1'b0 || wb_sel_b !== 4'hF || wb_dat_b !== 32'd0) bad_bus++;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (cc != 4 || lat != 5 || wb_cyc_b !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_timing: cyc=%0d lat=%0d cyc_now=%b, required 4 5 0", cc, lat, wb_cyc_b);
        end
        n_cmp++;
        if (rsp_err_b !== 1'b1 || rsp_dat_b !== 32'd0) begin
            n_err++;
            $display("FAIL timeout_rsp: err=%b dat=%h, required 1 0", rsp_err_b, rsp_dat_b);
        end
        n_cmp++;
        if (bad_ready != 0 || bad_bus != 0) begin
            n_err++;
            $display("FAIL timeout_ready_bus: ready_high=%0d bus_bad=%0d, required 0 0", bad_ready, bad_bus);
        end
        consume();
    endtask

    task automatic test_ack_expiry();
        int lat = 0, cc = 0, bad_bus = 0;
        rdt_c = 32'hA5A5A5A5;
        cmd_we = 1'b0; cmd_adr = 6'h08; cmd_dat = 32'd0; cmd_sel = 4'h3; valid_c = 1'b1;
        @(posedge clk); #1;
        valid_c = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            if (rsp_valid_c) begin
                lat = k;
                break;
            end
            ack_c = (k == 3);
            if (wb_stb_c !== wb_cyc_c) bad_bus++;
            if (wb_cyc_c) begin
                cc++;
                if (wb_adr_c !== 6'h08 || wb_we_c !== 1'b0 || wb_sel_c !== 4'h3 || wb_dat_c !== 32'd0) bad_bus++;
            end
            @(posedge clk); #1;
        end
        ack_c = 1'b0;
        n_cmp++;
        if (cc != 3 || lat != 4 || bad_bus != 0) begin
            n_err++;
            $display("FAIL ackexp_timing: cyc=%0d lat=%0d bus_bad=%0d, required 3 4 0", cc, lat, bad_bus);
        end
        n_cmp++;
        if (rsp_err_c !== 1'b0 || rsp_dat_c !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL ackexp_rsp: err=%b dat=%h, required 0 a5a5a5a5", rsp_err_c, rsp_dat_c);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat, cc, stall_bad = 0, stray_bad = 0;
        logic acc, bwe; logic [5:0] badr; logic [31:0] bdat; logic [3:0] bsel;
        run_cmd_a(1'b0, 6'h3C, 32'd0, 4'hF, lat, cc, acc, badr, bdat, bsel, bwe);
        n_cmp++;
        if (lat != 3 || rsp_dat_a !== 32'h12345678) begin
            n_err++;
            $display("FAIL bp_first_read: lat=%0d dat=%h, required 3 12345678", lat, rsp_dat_a);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (rsp_valid_a !== 1'b1 || rsp_dat_a !== 32'h12345678 || rsp_err_a !== 1'b0 || cmd_ready_a !== 1'b0)
                stall_bad++;
        end
        n_cmp++;
        if (stall_bad != 0) begin
            n_err++;
            $display("FAIL bp_stall_stable: bad_cycles=%0d, required 0", stall_bad);
        end
        consume();
        n_cmp++;
        if (wb_cyc_a !== 1'b0 || cmd_ready_a !== 1'b1 || rsp_valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL bp_gap: cyc=%b ready=%b valid=%b, required 0 1 0", wb_cyc_a, cmd_ready_a, rsp_valid_a);
        end
        run_cmd_a(1'b1, 6'h10, 32'hDEADBEEF, 4'h3, lat, cc, acc, badr, bdat, bsel, bwe);
        n_cmp++;
        if (acc !== 1'b1 || lat != 3 || mem[4] !== 32'h0000BEEF || rsp_dat_a !== 32'd0) begin
            n_err++;
            $display("FAIL b2b_second: acc=%b lat=%0d mem=%h dat=%h, required 1 3 0000beef 0",
                     acc, lat, mem[4], rsp_dat_a);
        end
        consume();
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (rsp_valid_a !== 1'b0 || wb_cyc_a !== 1'b0 || cmd_ready_a !== 1'b1) stray_bad++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (stray_bad != 0) begin
            n_err++;
            $display("FAIL stray_ack: bad_cycles=%0d, required 0", stray_bad);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        cmd_we = 1'b0; cmd_adr = 6'h30; cmd_dat = 32'd0; cmd_sel = 4'hF; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (wb_cyc_a !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_in_bus: cyc=%b, required 1", wb_cyc_a);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready_a !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_ready_in_rst: ready=%b, required 0", cmd_ready_a);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (wb_cyc_a !== 1'b0 || wb_stb_a !== 1'b0 || rsp_valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_drop: cyc=%b stb=%b valid=%b, required 0 0 0", wb_cyc_a, wb_stb_a, rsp_valid_a);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready_a !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_ready_after: ready=%b, required 1", cmd_ready_a);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rsp_valid_a !== 1'b0 || wb_cyc_a !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rstmid_no_rsp: bad_cycles=%0d, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_expiry();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
